// File: rtl/tetris_pkg.sv
// Shared board geometry and types for the Tetris playfield blocks.
package tetris_pkg;

    localparam int BOARD_ROWS = 8;
    localparam int BOARD_COLS = 4;
    localparam int BOARD_W    = BOARD_ROWS * BOARD_COLS;

    typedef logic [BOARD_W-1:0] board_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } clr_state_t;

    localparam logic [BOARD_COLS-1:0] ROW_FULL = {BOARD_COLS{1'b1}};

endpackage

// File: rtl/row_compact.sv
// Removes one row from the board; every row above it drops by one and the
// top row is refilled with empty cells.
module row_compact
    import tetris_pkg::*;
#(
    parameter int ROWS  = BOARD_ROWS,
    parameter int COLS  = BOARD_COLS,
    parameter int IDX_W = $clog2(ROWS)
) (
    input  logic [ROWS*COLS-1:0] board,
    input  logic [IDX_W-1:0]     row,
    output logic [ROWS*COLS-1:0] compacted
);

    // Rows below the removed one stay put, rows at or above it take the row
    // from directly above; the top row is never sourced, so it stays zero.
    always_comb begin
        compacted = '0;
        for (int r = 0; r < ROWS - 1; r++) begin
            if (r < int'(row)) begin
                compacted[r*COLS +: COLS] = board[r*COLS +: COLS];
            end else begin
                compacted[r*COLS +: COLS] = board[(r+1)*COLS +: COLS];
            end
        end
    end

endmodule

// File: rtl/line_clear_ctrl.sv
// Line-clear engine: captures the locked board, walks rows bottom-to-top and
// removes full rows one per CLEAR cycle, rechecking the row that drops in.
module line_clear_ctrl
    import tetris_pkg::*;
#(
    parameter int ROWS  = BOARD_ROWS,
    parameter int COLS  = BOARD_COLS,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ROWS*COLS-1:0] board_in,
    output logic                 busy,
    output logic                 done,
    output logic [ROWS*COLS-1:0] board_out,
    output logic [3:0]           lines_cleared,
    output logic [CNT_W-1:0]     total_lines
);

    localparam int IDX_W = $clog2(ROWS);
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);

    clr_state_t           state;
    logic [IDX_W-1:0]     row_idx;
    logic [COLS-1:0]      cur_row;
    logic                 row_full;
    logic [ROWS*COLS-1:0] compacted;

    assign cur_row  = board_out[int'(row_idx)*COLS +: COLS];
    assign row_full = (cur_row == {COLS{1'b1}});

    row_compact #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .IDX_W (IDX_W)
    ) u_row_compact (
        .board     (board_out),
        .row       (row_idx),
        .compacted (compacted)
    );

    // Control FSM with registered busy/done and the working board/counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            row_idx       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            board_out     <= '0;
            lines_cleared <= '0;
            total_lines   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        board_out     <= board_in;
                        lines_cleared <= '0;
                        row_idx       <= '0;
                        busy          <= 1'b1;
                        state         <= SCAN;
                    end
                end
                SCAN: begin
                    if (row_full) begin
                        state <= CLEAR;
                    end else if (row_idx == LAST_ROW) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        row_idx <= row_idx + 1'b1;
                    end
                end
                CLEAR: begin
                    board_out     <= compacted;
                    lines_cleared <= lines_cleared + 4'd1;
                    if (total_lines != {CNT_W{1'b1}}) begin
                        total_lines <= total_lines + 1'b1;
                    end
                    state <= SCAN;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Directed bench for line_clear_ctrl: table of single passes plus hand-written
// sequences for reset mid-pass, start hammering and counter saturation.
module tb_line_clear_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] board_in;
    logic        busy;
    logic        done;
    logic [31:0] board_out;
    logic [3:0]  lines_cleared;
    logic [15:0] total_lines;

    logic        start2;
    logic [31:0] board_in2;
    logic        busy2;
    logic        done2;
    logic [31:0] board_out2;
    logic [3:0]  lines_cleared2;
    logic [1:0]  total_lines2;

    int checks;
    int failures;
    int exp_total;

    typedef struct {
        string       name;
        logic [31:0] board;
        logic [31:0] exp_board;
        int          exp_lines;
        int          exp_cycles;
        bit          hammer;
    } vec_t;

    vec_t vecs[6];

    line_clear_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .board_in      (board_in),
        .busy          (busy),
        .done          (done),
        .board_out     (board_out),
        .lines_cleared (lines_cleared),
        .total_lines   (total_lines)
    );

    line_clear_ctrl #(.CNT_W(2)) sat_dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start2),
        .board_in      (board_in2),
        .busy          (busy2),
        .done          (done2),
        .board_out     (board_out2),
        .lines_cleared (lines_cleared2),
        .total_lines   (total_lines2)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One full pass on the main DUT; optionally holds start high throughout
    // the busy and done cycles to prove it is ignored.
    task automatic applyStimulus(input vec_t v);
        int  cycles;
        logic [31:0] held_board;
        logic [3:0]  held_lines;
        bit  extra_done;
        @(posedge clk); #1;
        start    = 1'b1;
        board_in = v.board;
        @(posedge clk); #1;
        start    = v.hammer;
        board_in = $urandom;
        cycles   = 1;
        checkOutput({v.name, " busy_after_start"}, 32'(busy), 32'd1);
        while (!done && cycles < 60) begin
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput({v.name, " done_seen"}, 32'(done), 32'd1);
        checkOutput({v.name, " done_cycle"}, 32'(cycles), 32'(v.exp_cycles));
        checkOutput({v.name, " board_out"}, board_out, v.exp_board);
        checkOutput({v.name, " lines_cleared"}, 32'(lines_cleared), 32'(v.exp_lines));
        exp_total = exp_total + v.exp_lines;
        if (exp_total > 65535) exp_total = 65535;
        checkOutput({v.name, " total_lines"}, 32'(total_lines), 32'(exp_total));
        checkOutput({v.name, " busy_on_done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput({v.name, " done_one_cycle"}, 32'(done), 32'd0);
        checkOutput({v.name, " idle_after_done"}, 32'(busy), 32'd0);
        held_board = board_out;
        held_lines = lines_cleared;
        extra_done = 1'b0;
        for (int i = 0; i < (v.hammer ? 30 : 3); i++) begin
            @(posedge clk); #1;
            if (done || busy) extra_done = 1'b1;
        end
        checkOutput({v.name, " no_extra_activity"}, 32'(extra_done), 32'd0);
        checkOutput({v.name, " board_hold"}, board_out, v.exp_board);
        checkOutput({v.name, " lines_hold"}, 32'(lines_cleared), 32'(v.exp_lines));
    endtask

    // One pass on the narrow-counter DUT.
    task automatic satPass(input string name, input logic [31:0] b,
                           input int exp_lines, input int exp_tot);
        int cycles;
        @(posedge clk); #1;
        start2    = 1'b1;
        board_in2 = b;
        @(posedge clk); #1;
        start2 = 1'b0;
        cycles = 1;
        while (!done2 && cycles < 60) begin
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput({name, " done_seen"}, 32'(done2), 32'd1);
        checkOutput({name, " lines_cleared"}, 32'(lines_cleared2), 32'(exp_lines));
        checkOutput({name, " total_lines"}, 32'(total_lines2), 32'(exp_tot));
        @(posedge clk); #1;
    endtask

    initial begin
        bit late_done;
        checks    = 0;
        failures  = 0;
        exp_total = 0;
        start     = 1'b0;
        board_in  = '0;
        start2    = 1'b0;
        board_in2 = '0;

        vecs[0] = '{"no_full",      32'h0000_0137, 32'h0000_0137, 0,  9, 1'b0};
        vecs[1] = '{"two_bottom",   32'h0000_03FF, 32'h0000_0003, 2, 13, 1'b0};
        vecs[2] = '{"non_adjacent", 32'h0F1F_2F01, 32'h0000_1201, 3, 15, 1'b0};
        vecs[3] = '{"empty",        32'h0000_0000, 32'h0000_0000, 0,  9, 1'b0};
        vecs[4] = '{"top_row_only", 32'hF000_0000, 32'h0000_0000, 1, 11, 1'b0};
        vecs[5] = '{"hammer_start", 32'h00F0_F0A5, 32'h0000_00A5, 2, 13, 1'b1};

        rst = 1'b1;
        #23;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset board_out", board_out, 32'd0);
        checkOutput("reset lines_cleared", 32'(lines_cleared), 32'd0);
        checkOutput("reset total_lines", 32'(total_lines), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
        end

        // Reset in the middle of a pass: everything clears at once and the
        // abandoned pass never signals done.
        $display("[TB] reset during SCAN");
        @(posedge clk); #1;
        start    = 1'b1;
        board_in = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("midreset busy", 32'(busy), 32'd0);
        checkOutput("midreset done", 32'(done), 32'd0);
        checkOutput("midreset board_out", board_out, 32'd0);
        checkOutput("midreset lines_cleared", 32'(lines_cleared), 32'd0);
        checkOutput("midreset total_lines", 32'(total_lines), 32'd0);
        exp_total = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        late_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done || busy) late_done = 1'b1;
        end
        checkOutput("midreset no_done_after", 32'(late_done), 32'd0);

        applyStimulus('{"full_board", 32'hFFFF_FFFF, 32'h0000_0000, 8, 25, 1'b0});
        applyStimulus('{"after_full", 32'h0000_000F, 32'h0000_0000, 1, 11, 1'b0});
        checkOutput("total_after_nine", 32'(total_lines), 32'd9);

        // Two-bit counter: 2 lines, then 3 more must stick at 3.
        satPass("sat_first", 32'h0000_00FF, 2, 2);
        satPass("sat_clamp", 32'h0000_0FFF, 3, 3);
        satPass("sat_hold",  32'h0000_000F, 1, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
